// File: rtl/alu_txn_initiator.sv
// Initiator for the packed-struct add/sub ALU: credit-limited request issue, latency
// tracking of in-flight ops, and an in-order response FIFO presented on a valid/ready port.
module alu_txn_initiator #(
    parameter int RSP_DEPTH = 4,
    parameter int ALU_LAT   = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic [16:0] alu_req,
    input  logic [8:0]  alu_rsp,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_result,
    output logic        rsp_flag,
    output logic        rsp_op,
    output logic [15:0] txn_count
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam logic [PW:0] DEPTH_C = RSP_DEPTH[PW:0];

    typedef struct packed {
        logic       op;
        logic [7:0] result;
        logic       flag;
    } rsp_t;

    logic [PW:0]        used_q, used_d;
    logic [16:0]        alu_req_q;
    logic               issue_vld_q;
    logic [ALU_LAT-1:0] trk_vld_q;
    logic [ALU_LAT-1:0] trk_op_q;
    rsp_t               mem_q [RSP_DEPTH];
    logic [PW:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]        fifo_cnt;
    logic [15:0]        txn_count_q;
    logic               accept, pop, fifo_wr, fifo_full;
    rsp_t               head;

    // Credits cover everything from accept to pop, so the FIFO can never overflow.
    assign req_ready = reset_n && (used_q < DEPTH_C);
    assign accept    = req_valid && req_ready;
    assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
    assign fifo_full = (fifo_cnt == DEPTH_C);
    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign fifo_wr   = trk_vld_q[ALU_LAT-1];

    always_comb begin
        used_d = used_q;
        case ({accept, pop})
            2'b10:   used_d = used_q + 1'b1;
            2'b01:   used_d = used_q - 1'b1;
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            used_q      <= '0;
            alu_req_q   <= '0;
            issue_vld_q <= 1'b0;
            trk_vld_q   <= '0;
            trk_op_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            txn_count_q <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            used_q      <= used_d;
            issue_vld_q <= accept;
            alu_req_q   <= accept ? {req_op, req_a, req_b} : 17'd0;
            // Tracker mirrors the ALU pipeline so the op tag lines up with alu_rsp.
            trk_vld_q[0] <= issue_vld_q;
            trk_op_q[0]  <= alu_req_q[16];
            for (int i = 1; i < ALU_LAT; i++) begin
                trk_vld_q[i] <= trk_vld_q[i-1];
                trk_op_q[i]  <= trk_op_q[i-1];
            end
            if (fifo_wr) begin
                mem_q[wr_ptr_q[PW-1:0]] <= '{op: trk_op_q[ALU_LAT-1],
                                             result: alu_rsp[8:1],
                                             flag: alu_rsp[0]};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                if (txn_count_q != 16'hFFFF) txn_count_q <= txn_count_q + 1'b1;
            end
        end
    end

    assign head       = mem_q[rd_ptr_q[PW-1:0]];
    assign alu_req    = alu_req_q;
    assign rsp_result = head.result;
    assign rsp_flag   = head.flag;
    assign rsp_op     = head.op;
    assign txn_count  = txn_count_q;

endmodule
